// File: rtl/frida_pkg.sv
// Shared types for the FRIDA ADC readout path: acquisition modes, sequencer
// states and the result-word packing helper for the default array geometry.
package frida_pkg;

    localparam int DEF_N_ADC      = 16;
    localparam int DEF_N_BITS     = 12;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_CW         = $clog2(DEF_N_ADC);

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_SCAN   = 2'd1,
        MODE_CONT   = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CONVERT = 2'd2,
        ST_STORE   = 2'd3
    } state_t;

    // Channel tag sits above the data bits, matching the FIFO word layout.
    typedef struct packed {
        logic [DEF_CW-1:0]     chan;
        logic [DEF_N_BITS-1:0] data;
    } adc_word_t;

    function automatic adc_word_t adc_word_pack(input logic [DEF_CW-1:0]     chan,
                                                input logic [DEF_N_BITS-1:0] data);
        adc_word_t w;
        w.chan = chan;
        w.data = data;
        return w;
    endfunction

endpackage

// File: rtl/frida_sync_fifo.sv
// Single-clock FIFO with flush; read data is held at zero while empty so the
// consumer never sees stale words after reset or flush.
module frida_sync_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int CNTW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNTW-1:0]  count;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == CNTW'(DEPTH));
    assign empty = (count == '0);
    assign do_rd = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/adc_readout_seq.sv
// Readout sequencer: steers the comparator mux, assembles N_BITS decisions
// per word MSB-first and queues channel-tagged words behind a valid/ready port.
module adc_readout_seq
    import frida_pkg::*;
#(
    parameter  int N_ADC      = DEF_N_ADC,
    parameter  int N_BITS     = DEF_N_BITS,
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int CW         = $clog2(N_ADC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [CW-1:0]     chan_sel,
    input  logic [N_ADC-1:0]  comp_in,
    input  logic              cmp_strobe,
    output logic [CW-1:0]     mux_sel,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] out_data,
    output logic [CW-1:0]     out_chan,
    output logic              overflow,
    input  logic              clear,
    output state_t            state_dbg
);

    // Output handshake: a word transfers on out_valid && out_ready; while
    // out_valid is high and out_ready low, out_data/out_chan hold stable.

    localparam int            BCW      = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int            WW       = CW + N_BITS;
    localparam logic [CW-1:0]  LAST_CH  = CW'(N_ADC - 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(N_BITS - 1);

    state_t            state;
    mode_t             mode_q;
    logic [N_BITS-1:0] shift_q;
    logic [BCW-1:0]    bit_cnt;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WW-1:0]     fifo_rdata;

    assign push      = (state == ST_STORE);
    assign pop       = out_valid && out_ready;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            mode_q  <= MODE_SINGLE;
            mux_sel <= '0;
            busy    <= 1'b0;
            shift_q <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_ARM;
                        busy    <= 1'b1;
                        mode_q  <= (mode == 2'd3) ? MODE_SINGLE : mode_t'(mode);
                        mux_sel <= (chan_sel > LAST_CH) ? LAST_CH : chan_sel;
                    end
                end
                // Mux settle cycle: strobes are ignored and the word restarts.
                ST_ARM: begin
                    shift_q <= '0;
                    bit_cnt <= '0;
                    if (stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    if (stop) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        shift_q <= '0;
                        bit_cnt <= '0;
                    end else if (cmp_strobe) begin
                        shift_q <= {shift_q[N_BITS-2:0], comp_in[mux_sel]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= ST_STORE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                // The push happens this cycle regardless of stop; only the
                // follow-on acquisition is cancelled.
                ST_STORE: begin
                    if (stop || mode_q == MODE_SINGLE ||
                        (mode_q == MODE_SCAN && mux_sel == LAST_CH)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= ST_ARM;
                        if (mode_q == MODE_SCAN) mux_sel <= mux_sel + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // A clear in the same cycle as a dropped push wins: the flag stays low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                overflow <= 1'b0;
        else if (clear)                         overflow <= 1'b0;
        else if (push && fifo_full && !pop)     overflow <= 1'b1;
    end

    frida_sync_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (clear),
        .wr_en   (push),
        .wr_data ({mux_sel, shift_q}),
        .rd_en   (pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid            = !fifo_empty;
    assign {out_chan, out_data} = fifo_rdata;

endmodule
